// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised Moore serial pattern detector with KMP fallback table
module seq_detect_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       signal,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       overlap,
  output logic                       out,
  output logic [$clog2(LEN+1)-1:0]   state,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int             SW    = $clog2(LEN + 1);
  localparam int             NS    = 1 << SW;
  localparam logic [SW-1:0]  LEN_S = SW'(LEN);

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // Evaluated only on constants, so it collapses to a fixed table.
  function automatic logic [SW-1:0] delta(input int k, input logic b);
    int             best;
    int             m;
    logic           ok;
    logic           sb;
    logic [LEN-1:0] sh;
    best = 0;
    for (int j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < LEN; i++) begin
          if (i < j) begin
            m = k + 1 - j + i;
            if (m < k) begin
              sh = PATTERN >> (LEN - 1 - m);
              sb = sh[0];
            end else begin
              sb = b;
            end
            sh = PATTERN >> (LEN - 1 - i);
            if (sb != sh[0]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best[SW-1:0];
  endfunction

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  // Transition table; encodings above LEN fall back to state 0.
  // Row LEN equals delta(border(LEN), b), i.e. the overlapping continuation.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam logic [SW-1:0] N0 = (k <= LEN) ? delta(k, 1'b0) : '0;
    localparam logic [SW-1:0] N1 = (k <= LEN) ? delta(k, 1'b1) : '0;
    assign nxt0[k] = N0;
    assign nxt1[k] = N1;
  end

  logic [SW-1:0]    state_q, state_d, nb;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q;

  // Next state: table lookup, restart from 0 after a match when not overlapping.
  always_comb begin
    nb = signal ? nxt1[state_q] : nxt0[state_q];
    if (state_q == LEN_S && !overlap) begin
      nb = signal ? nxt1[0] : nxt0[0];
    end
    state_d = state_q;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      state_d = nb;
    end
  end

  // State, registered match flag and saturating match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= (state_d == LEN_S);
      if (clr) begin
        cnt_q <= '0;
      end else if (en && state_d == LEN_S && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign state     = state_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - scoreboard bench for seq_detect_param
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst, signal, en, clr, overlap;

  logic [2:0] st0, st1, st2;
  logic [0:0] st3;
  logic       out0, out1, out2, out3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int    which;
    int    st;
    bit    o;
    int    cnt;
    string nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  seq_detect_param dut0 (
    .clk(clk), .rst(rst), .signal(signal), .en(en), .clr(clr), .overlap(overlap),
    .out(out0), .state(st0), .match_cnt(cnt0)
  );

  seq_detect_param #(.LEN(4), .PATTERN(4'b1111), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .signal(signal), .en(en), .clr(clr), .overlap(overlap),
    .out(out1), .state(st1), .match_cnt(cnt1)
  );

  seq_detect_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .signal(signal), .en(en), .clr(clr), .overlap(overlap),
    .out(out2), .state(st2), .match_cnt(cnt2)
  );

  seq_detect_param #(.LEN(1), .PATTERN(1'b1), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .signal(signal), .en(en), .clr(clr), .overlap(overlap),
    .out(out3), .state(st3), .match_cnt(cnt3)
  );

  task automatic chk(input string nm, input string field, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d", nm, field, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input bit b, input bit e, input bit c, input int w,
                      input int st, input bit o, input int cnt, input string nm);
    exp_t x;
    signal = b;
    en     = e;
    clr    = c;
    x.which = w; x.st = st; x.o = o; x.cnt = cnt; x.nm = nm;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: compare the selected instance against the oldest expectation.
  initial begin
    exp_t e;
    int   a_st, a_cnt;
    bit   a_o;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.which)
          0:       begin a_st = int'(st0); a_o = out0; a_cnt = int'(cnt0); end
          1:       begin a_st = int'(st1); a_o = out1; a_cnt = int'(cnt1); end
          2:       begin a_st = int'(st2); a_o = out2; a_cnt = int'(cnt2); end
          default: begin a_st = int'(st3); a_o = out3; a_cnt = int'(cnt3); end
        endcase
        chk(e.nm, "state", a_st, e.st);
        chk(e.nm, "out", int'(a_o), int'(e.o));
        chk(e.nm, "match_cnt", a_cnt, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int         st_e, cnt_e;
    pat     = 4'b1011;
    rst     = 1'b0;
    signal  = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    overlap = 1'b1;
    @(negedge clk);

    // Reset dominates accepted matching bits.
    step(1, 1, 0, 0, 0, 0, 0, "rst_a");
    step(1, 1, 0, 1, 0, 0, 0, "rst_b");
    step(1, 1, 0, 2, 0, 0, 0, "rst_c");
    step(1, 1, 0, 3, 0, 0, 0, "rst_d");
    rst = 1'b1;

    // T1: overlapping 1011 on 1,0,1,1,0,1,1
    overlap = 1'b1;
    step(1, 1, 0, 0, 1, 0, 0, "t1_b1");
    step(0, 1, 0, 0, 2, 0, 0, "t1_b2");
    step(1, 1, 0, 0, 3, 0, 0, "t1_b3");
    step(1, 1, 0, 0, 4, 1, 1, "t1_b4");
    step(0, 1, 0, 0, 2, 0, 1, "t1_b5");
    step(1, 1, 0, 0, 3, 0, 1, "t1_b6");
    step(1, 1, 0, 0, 4, 1, 2, "t1_b7");

    // T2: non-overlapping, same stream; clr discards its bit
    overlap = 1'b0;
    step(1, 1, 1, 0, 0, 0, 0, "t2_clr");
    step(1, 1, 0, 0, 1, 0, 0, "t2_b1");
    step(0, 1, 0, 0, 2, 0, 0, "t2_b2");
    step(1, 1, 0, 0, 3, 0, 0, "t2_b3");
    step(1, 1, 0, 0, 4, 1, 1, "t2_b4");
    step(0, 1, 0, 0, 0, 0, 1, "t2_b5");
    step(1, 1, 0, 0, 1, 0, 1, "t2_b6");
    step(1, 1, 0, 0, 1, 0, 1, "t2_b7");

    // T3: three stall cycles after every bit
    step(0, 1, 1, 0, 0, 0, 0, "t3_clr");
    for (int i = 0; i < 4; i++) begin
      st_e  = i + 1;
      cnt_e = (i == 3) ? 1 : 0;
      step(pat[3-i], 1, 0, 0, st_e, (i == 3), cnt_e, "t3_bit");
      for (int s = 0; s < 3; s++) begin
        step(s[0], 0, 0, 0, st_e, (i == 3), cnt_e, "t3_stall");
      end
    end

    // T4: 1111 with seven ones, both modes
    overlap = 1'b1;
    step(0, 1, 1, 1, 0, 0, 0, "t4_clr_ov");
    for (int i = 0; i < 7; i++) begin
      st_e  = (i < 3) ? i + 1 : 4;
      cnt_e = (i < 3) ? 0 : i - 2;
      step(1, 1, 0, 1, st_e, (st_e == 4), cnt_e, "t4_ov");
    end
    overlap = 1'b0;
    step(0, 1, 1, 1, 0, 0, 0, "t4_clr_nov");
    for (int i = 0; i < 7; i++) begin
      st_e  = (i % 4) + 1;
      cnt_e = (i >= 3) ? 1 : 0;
      step(1, 1, 0, 1, st_e, (st_e == 4), cnt_e, "t4_nov");
    end

    // T5: 2-bit counter saturates, then clr with an accepted bit
    overlap = 1'b1;
    step(0, 1, 1, 2, 0, 0, 0, "t5_clr0");
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        cnt_e = (i == 3) ? r + 1 : r;
        if (cnt_e > 3) cnt_e = 3;
        step(pat[3-i], 1, 0, 2, i + 1, (i == 3), cnt_e, "t5_sat");
      end
    end
    step(1, 1, 1, 2, 0, 0, 0, "t5_clr");

    // LEN=1: every 1 is a match even without overlap
    overlap = 1'b0;
    step(0, 1, 1, 3, 0, 0, 0, "len1_clr");
    step(1, 1, 0, 3, 1, 1, 1, "len1_a");
    step(1, 1, 0, 3, 1, 1, 2, "len1_b");
    step(0, 1, 0, 3, 0, 0, 2, "len1_c");
    step(1, 1, 0, 3, 1, 1, 3, "len1_d");

    // T6: asynchronous reset mid-pattern
    overlap = 1'b1;
    step(0, 1, 1, 0, 0, 0, 0, "t6_clr");
    step(1, 1, 0, 0, 1, 0, 0, "t6_b1");
    step(0, 1, 0, 0, 2, 0, 0, "t6_b2");
    step(1, 1, 0, 0, 3, 0, 0, "t6_b3");
    #2 rst = 1'b0;
    #1;
    chk("t6_async", "state", int'(st0), 0);
    chk("t6_async", "out", int'(out0), 0);
    #1 rst = 1'b1;
    step(1, 1, 0, 0, 1, 0, 0, "t6_after");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("drain", "pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
